// File: rtl/hall_pkg.sv
// Shared Hall-sensor definitions: code/sector lookup, forward order and FSM states.
// The same lookup is intended for reuse by the commutation logic.
package hall_pkg;

  localparam int unsigned HALL_CODE_W = 3;
  localparam int unsigned SECTOR_W    = 3;
  localparam int unsigned NUM_SECTORS = 6;

  // Forward rotation order; element [i] is the code of sector i.
  localparam logic [NUM_SECTORS-1:0][HALL_CODE_W-1:0] HALL_FWD_SEQ =
    {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  typedef enum logic [0:0] {
    ST_ACQ = 1'b0,
    ST_RUN = 1'b1
  } hall_state_e;

  typedef struct packed {
    logic                illegal;
    logic [SECTOR_W-1:0] sector;
  } hall_lookup_t;

  function automatic hall_lookup_t hall_lookup(input logic [HALL_CODE_W-1:0] code);
    hall_lookup_t r;
    r.illegal = 1'b1;
    r.sector  = '0;
    for (int i = 0; i < NUM_SECTORS; i++) begin
      if (HALL_FWD_SEQ[i] == code) begin
        r.illegal = 1'b0;
        r.sector  = SECTOR_W'(i);
      end
    end
    return r;
  endfunction

  // Neighbouring sector in the forward (fwd=1) or reverse (fwd=0) direction.
  function automatic logic [SECTOR_W-1:0] sector_step(input logic [SECTOR_W-1:0] s,
                                                      input logic fwd);
    if (fwd) begin
      return (s == SECTOR_W'(NUM_SECTORS - 1)) ? '0 : s + SECTOR_W'(1);
    end
    return (s == '0) ? SECTOR_W'(NUM_SECTORS - 1) : s - SECTOR_W'(1);
  endfunction

endpackage

// File: rtl/hall_decoder_if.sv
// Hall sensor lines in, decoded position/speed feedback out.
interface hall_decoder_if
  import hall_pkg::*;
#(
  parameter int unsigned CNT_W = 24
);
  logic                H1;
  logic                H2;
  logic                H3;
  logic                err_clr;
  logic [SECTOR_W-1:0] sector;
  logic                sector_valid;
  logic                dir;
  logic                edge_pulse;
  logic [CNT_W-1:0]    period;
  logic                period_valid;
  logic                stalled;
  logic                hall_err;

  modport master (
    output H1, H2, H3, err_clr,
    input  sector, sector_valid, dir, edge_pulse, period, period_valid, stalled, hall_err
  );

  modport slave (
    input  H1, H2, H3, err_clr,
    output sector, sector_valid, dir, edge_pulse, period, period_valid, stalled, hall_err
  );
endinterface

// File: rtl/hall_filter.sv
// Two-flop synchronizer plus debounce: a code is accepted after FILT_LEN identical samples.
// chg pulses for one cycle whenever the accepted code changes.
module hall_filter
  import hall_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HALL_CODE_W-1:0] raw,
  output logic [HALL_CODE_W-1:0] code,
  output logic                   chg
);

  localparam int unsigned     STAB_W   = 8;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILT_LEN);

  logic [HALL_CODE_W-1:0] sync1_q;
  logic [HALL_CODE_W-1:0] sync2_q;
  logic [HALL_CODE_W-1:0] cand_q;
  logic [STAB_W-1:0]      stab_q;
  logic [STAB_W-1:0]      stab_d;
  logic                   accept;

  // Stability count includes the current sample; any difference restarts it at one.
  always_comb begin
    stab_d = stab_q;
    if (sync2_q != cand_q) begin
      stab_d = STAB_W'(1);
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end
    accept = (stab_d == STAB_MAX) && (sync2_q != code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      code    <= '0;
      chg     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      stab_q  <= stab_d;
      chg     <= accept;
      if (accept) begin
        code <= sync2_q;
      end
    end
  end

endmodule

// File: rtl/hall_decoder.sv
// BLDC Hall decoder: sector, direction, edge-to-edge period, stall and error detection.
module hall_decoder
  import hall_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned STALL_LIMIT = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  hall_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [HALL_CODE_W-1:0] code;
  logic                   chg;
  hall_lookup_t           lk;
  logic                   adj_fwd;
  logic                   adj_rev;
  logic [CNT_W-1:0]       cnt_inc;

  hall_state_e         state_q,   state_d;
  logic [SECTOR_W-1:0] sector_q,  sector_d;
  logic                valid_q,   valid_d;
  logic                dir_q,     dir_d;
  logic                edge_q,    edge_d;
  logic [CNT_W-1:0]    period_q,  period_d;
  logic                pv_q,      pv_d;
  logic                stalled_q, stalled_d;
  logic                err_q,     err_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                first_q,   first_d;
  logic                err_set;

  hall_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  ({bus.H1, bus.H2, bus.H3}),
    .code (code),
    .chg  (chg)
  );

  assign lk      = hall_lookup(code);
  assign adj_fwd = (lk.sector == sector_step(sector_q, 1'b1));
  assign adj_rev = (lk.sector == sector_step(sector_q, 1'b0));
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACQ;
      sector_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= 1'b1;
      edge_q    <= 1'b0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      stalled_q <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      sector_q  <= sector_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      edge_q    <= edge_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      stalled_q <= stalled_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sector_d  = sector_q;
    valid_d   = valid_q;
    dir_d     = dir_q;
    edge_d    = 1'b0;
    period_d  = period_q;
    pv_d      = 1'b0;
    stalled_d = stalled_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    err_set   = 1'b0;

    case (state_q)
      ST_ACQ: begin
        if (chg) begin
          if (lk.illegal) begin
            err_set = 1'b1;
            valid_d = 1'b0;
          end else if (valid_q && (adj_fwd || adj_rev)) begin
            // Resuming after a stall: still-valid sector makes this a real edge.
            edge_d    = 1'b1;
            sector_d  = lk.sector;
            dir_d     = adj_fwd;
            stalled_d = 1'b0;
            cnt_d     = '0;
            first_d   = 1'b0;
            state_d   = ST_RUN;
          end else begin
            sector_d = lk.sector;
            valid_d  = 1'b1;
            cnt_d    = '0;
            first_d  = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (chg) begin
          if (lk.illegal || !(adj_fwd || adj_rev)) begin
            err_set = 1'b1;
            valid_d = 1'b0;
            state_d = ST_ACQ;
          end else begin
            // Period only spans two edges in the same direction.
            if (!first_q && (adj_fwd == dir_q)) begin
              period_d = cnt_inc;
              pv_d     = 1'b1;
            end
            edge_d    = 1'b1;
            sector_d  = lk.sector;
            dir_d     = adj_fwd;
            stalled_d = 1'b0;
            cnt_d     = '0;
            first_d   = 1'b0;
          end
        end else if (cnt_q == STALL_LAST) begin
          stalled_d = 1'b1;
          state_d   = ST_ACQ;
        end
      end
      default: state_d = ST_ACQ;
    endcase

    err_d = err_set | (err_q & ~bus.err_clr);
  end

  assign bus.sector       = sector_q;
  assign bus.sector_valid = valid_q;
  assign bus.dir          = dir_q;
  assign bus.edge_pulse   = edge_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.stalled      = stalled_q;
  assign bus.hall_err     = err_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed and randomized checks of hall_decoder against a timestamp-based reference model.
module tb_hall_decoder;

  localparam int unsigned FILT_LEN    = 4;
  localparam int unsigned CNT_W       = 24;
  localparam int unsigned STALL_LIMIT = 1000;
  localparam int unsigned LAT         = FILT_LEN + 3;
  localparam longint      MAXP        = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hall_decoder_if #(.CNT_W(CNT_W)) bus ();

  hall_decoder #(
    .FILT_LEN    (FILT_LEN),
    .CNT_W       (CNT_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int fwd_codes [6] = '{5, 4, 6, 2, 3, 1};

  // Reference model state, in terms of sectors and edge timestamps.
  bit     m_track, m_valid, m_dir, m_stalled, m_err, m_first, m_edge, m_pv;
  int     m_sector;
  longint m_period, m_tlast;
  logic [2:0] cur_raw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int code_idx(input logic [2:0] c);
    int r = -1;
    for (int i = 0; i < 6; i++) if (fwd_codes[i] == int'(c)) r = i;
    return r;
  endfunction

  function automatic bit stalled_now(input longint now);
    return m_stalled || (m_track && (now - m_tlast) >= longint'(STALL_LIMIT));
  endfunction

  task automatic model_reset();
    m_track = 0; m_valid = 0; m_dir = 1; m_stalled = 1; m_err = 0; m_first = 1;
    m_edge = 0; m_pv = 0; m_sector = 0; m_period = 0; m_tlast = 0;
  endtask

  // Effect of an accepted code change whose outputs appear at cycle t.
  task automatic model_step(input logic [2:0] code, input longint t, input bit clr);
    int idx, d;
    bit set_err;
    set_err = 0;
    m_edge  = 0;
    m_pv    = 0;
    if (m_track && (t - m_tlast) > longint'(STALL_LIMIT)) begin
      m_track   = 0;
      m_stalled = 1;
    end
    idx = code_idx(code);
    if (idx < 0) begin
      set_err = 1; m_valid = 0; m_track = 0;
    end else begin
      d = (idx - m_sector + 6) % 6;
      if (!m_track) begin
        if (m_valid && (d == 1 || d == 5)) begin
          m_edge = 1; m_dir = (d == 1); m_stalled = 0; m_first = 0;
        end else begin
          m_valid = 1; m_first = 1;
        end
        m_sector = idx; m_track = 1; m_tlast = t;
      end else if (d == 1 || d == 5) begin
        if (!m_first && ((d == 1) == m_dir)) begin
          m_pv     = 1;
          m_period = ((t - m_tlast) > MAXP) ? MAXP : (t - m_tlast);
        end
        m_edge = 1; m_dir = (d == 1); m_sector = idx; m_stalled = 0; m_first = 0;
        m_tlast = t;
      end else begin
        set_err = 1; m_valid = 0; m_track = 0;
      end
    end
    if (set_err) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/sector"},       32'(bus.sector),       32'(m_sector));
    chk({tag, "/sector_valid"}, 32'(bus.sector_valid), 32'(m_valid));
    chk({tag, "/dir"},          32'(bus.dir),          32'(m_dir));
    chk({tag, "/edge_pulse"},   32'(bus.edge_pulse),   32'(m_edge));
    chk({tag, "/period_valid"}, 32'(bus.period_valid), 32'(m_pv));
    chk({tag, "/period"},       32'(bus.period),       32'(m_period));
    chk({tag, "/stalled"},      32'(bus.stalled),      32'(stalled_now(cyc)));
    chk({tag, "/hall_err"},     32'(bus.hall_err),     32'(m_err));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "/idle_edge"}, 32'(bus.edge_pulse),   32'(0));
    chk({tag, "/idle_pv"},   32'(bus.period_valid), 32'(0));
    chk({tag, "/stalled"},   32'(bus.stalled),      32'(stalled_now(cyc)));
  endtask

  // Expect an accepted change of `code` LAT cycles from now; runs `hold` cycles in total.
  task automatic expect_step(input string tag, input logic [2:0] code, input int hold,
                             input bit clr);
    int n;
    n = (hold < int'(LAT)) ? int'(LAT) : hold;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == int'(LAT)) begin
        bus.err_clr = 1'b0;
        model_step(code, cyc, clr);
        chk_all(tag);
      end else begin
        idle_chk(tag);
        if (clr && i == int'(LAT) - 1) bus.err_clr = 1'b1;
      end
    end
  endtask

  task automatic apply_step(input string tag, input logic [2:0] code, input int hold,
                            input bit clr);
    {bus.H1, bus.H2, bus.H3} = code;
    cur_raw = code;
    expect_step(tag, code, hold, clr);
  endtask

  // Pulse `code` for n cycles then return to the previous raw code.
  task automatic glitch(input string tag, input logic [2:0] code, input int n);
    logic [2:0] base;
    base = cur_raw;
    {bus.H1, bus.H2, bus.H3} = code;
    for (int i = 1; i <= n + int'(LAT) + 6; i++) begin
      @(posedge clk); #1;
      if (n >= int'(FILT_LEN) && i == int'(LAT)) begin
        model_step(code, cyc, 0);
        chk_all({tag, "/in"});
      end else if (n >= int'(FILT_LEN) && i == n + int'(LAT)) begin
        model_step(base, cyc, 0);
        chk_all({tag, "/out"});
      end else begin
        idle_chk(tag);
      end
      if (i == n) {bus.H1, bus.H2, bus.H3} = base;
    end
    chk({tag, "/sector"},   32'(bus.sector),   32'(m_sector));
    chk({tag, "/hall_err"}, 32'(bus.hall_err), 32'(m_err));
  endtask

  initial begin
    logic [2:0] c;
    int idx, r, hold;
    bus.err_clr = 1'b0;
    {bus.H1, bus.H2, bus.H3} = 3'b000;
    cur_raw = 3'b000;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; idle_chk("post_reset"); end

    // Forward rotation through all sectors and the wrap.
    apply_step("fwd0", 3'b101, 500, 0);
    apply_step("fwd1", 3'b100, 500, 0);
    apply_step("fwd2", 3'b110, 500, 0);
    apply_step("fwd3", 3'b010, 500, 0);
    apply_step("fwd4", 3'b011, 500, 0);
    apply_step("fwd5", 3'b001, 500, 0);
    apply_step("fwd_wrap", 3'b101, 500, 0);

    // Direction reversal.
    apply_step("rev_a", 3'b100, 500, 0);
    apply_step("rev_b", 3'b110, 500, 0);
    apply_step("rev_c", 3'b100, 500, 0);
    apply_step("rev_d", 3'b101, 500, 0);

    // Glitches shorter than and equal to the filter length.
    apply_step("gl_base", 3'b100, 500, 0);
    glitch("glitch3", 3'b110, 3);
    glitch("glitch4", 3'b110, 4);

    // Illegal codes, recovery, skip with simultaneous clear, then clear.
    apply_step("ill_111", 3'b111, 10, 0);
    apply_step("ill_000", 3'b000, 50, 0);
    apply_step("ill_ref", 3'b010, 500, 0);
    apply_step("skip_clr", 3'b001, 100, 1);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    m_err = 0;
    chk("err_clear", 32'(bus.hall_err), 32'(0));
    apply_step("skip_ref", 3'b011, 100, 0);

    // Stall and resume.
    apply_step("st_a", 3'b010, 100, 0);
    apply_step("st_hold", 3'b110, 1200, 0);
    apply_step("st_resume", 3'b100, 300, 0);
    apply_step("st_next", 3'b101, 300, 0);

    // Reset in the cycle an edge and period pulse are high.
    apply_step("rst_edge", 3'b001, int'(LAT), 0);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst_mid");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_step("rst_reacq", 3'b001, 300, 0);

    // Random walk: mostly adjacent moves, occasional arbitrary codes, long holds and clears.
    for (int s = 0; s < 40; s++) begin
      idx = code_idx(cur_raw);
      r = int'($urandom_range(0, 9));
      if (idx >= 0 && r < 5)      c = 3'(fwd_codes[(idx + 1) % 6]);
      else if (idx >= 0 && r < 8) c = 3'(fwd_codes[(idx + 5) % 6]);
      else                        c = 3'($urandom_range(0, 7));
      if (c == cur_raw) c = cur_raw ^ 3'b001;
      hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(900, 1300))
                                         : int'($urandom_range(LAT, 400));
      apply_step("rand", c, hold, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
